// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide execution unit for KGP-RISC.
//
// Takes the two register-file read operands, computes the result over multiple cycles and
// drives the register-file write port for one cycle on completion. The issue stage stalls
// while busy is high.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   start          issue request, sampled only in IDLE
//   op             00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
//   src_a, src_b   operands (multiplicand/dividend, multiplier/divisor)
//   dest_reg       destination register index
//   sign_en        (SIGNED_OPS_EN only) treat operands as two's complement, sampled with start
//   busy           high while an operation is in flight (RUN and DONE)
//   done           one-cycle completion pulse
//   wb_reg_write   register-file write enable, equal to done
//   wb_write_reg   destination index captured at start
//   wb_write_data  selected result, held until the next completion
//
// Build option: define SIGNED_OPS_EN to add the sign_en port and signed operation support.
//
// Timing: the accepting edge E0 loads the operands. Edges E0+1..E0+WIDTH each perform one
// iteration. Edge E0+WIDTH+1 applies sign correction and result selection, loads wb_*, and
// enters DONE. A divide by zero skips the iterations, so DONE is entered on E0+1.
module mul_div_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
`ifdef SIGNED_OPS_EN
  input  logic                  sign_en,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [WIDTH-1:0]      wb_write_data
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntFinal = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]      acc_q, acc_d;     // product, or {remainder, quotient}
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    neg_a_q, neg_a_d;
  logic                    neg_b_q, neg_b_d;
  logic                    dz_q, dz_d;
  logic [REG_ADDR_W-1:0]   wb_reg_q, wb_reg_d;
  logic [WIDTH-1:0]        wb_data_q, wb_data_d;

  // Operand magnitudes used at acceptance
  logic             sign_req;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
`ifdef SIGNED_OPS_EN
    sign_req = sign_en;
`else
    sign_req = 1'b0;
`endif
    sa    = sign_req & src_a[WIDTH-1];
    sb    = sign_req & src_b[WIDTH-1];
    mag_a = sa ? -src_a : src_a;
    mag_b = sb ? -src_b : src_b;
  end

  // One shift-add multiply step: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole product right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // One restoring divide step: the trial value is the remainder shifted left with the next
  // dividend bit brought in; it needs WIDTH+1 bits before the compare.
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = div_trial >= {1'b0, opnd_q};
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end

  // Result selection with sign correction
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, result;

  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_s  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q) begin
      // No iterations ran: the low half still holds |src_a|, so restoring its sign
      // reproduces src_a exactly (including the most negative value).
      quo_s = '1;
      rem_s = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
    unique case (op_q)
      2'b00:   result = prod_s[WIDTH-1:0];
      2'b01:   result = prod_s[2*WIDTH-1:WIDTH];
      2'b10:   result = quo_s;
      2'b11:   result = rem_s;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    dz_d      = dz_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          dest_d  = dest_reg;
          cnt_d   = '0;
          neg_a_d = sa;
          neg_b_d = sb;
          dz_d    = op[1] && (src_b == '0);
          if (op[1]) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
          state_d = StRun;
        end
      end
      StRun: begin
        if (dz_q || (cnt_q == CntFinal)) begin
          wb_reg_d  = dest_q;
          wb_data_d = result;
          state_d   = StDone;
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dest_q    <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      dz_q      <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      dz_q      <= dz_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign wb_reg_write  = done;
  assign wb_write_reg  = wb_reg_q;
  assign wb_write_data = wb_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized operations checked
// against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest_reg;
`ifdef SIGNED_OPS_EN
  logic        sign_en;
`endif
  logic        busy;
  logic        done;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  int n_cmp;
  int n_err;

  mul_div_unit #(
    .WIDTH      (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .src_a         (src_a),
    .src_b         (src_b),
    .dest_reg      (dest_reg),
`ifdef SIGNED_OPS_EN
    .sign_en       (sign_en),
`endif
    .busy          (busy),
    .done          (done),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic straight from the operation definitions.
  function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b, input logic sgn);
    longint la, lb, p, q, r;
    la = sgn ? longint'($signed(a)) : longint'(a);
    lb = sgn ? longint'($signed(b)) : longint'(b);
    if (!mop[1]) begin
      p = la * lb;
      return mop[0] ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return mop[0] ? a : 32'hFFFF_FFFF;
    q = la / lb;
    r = la % lb;
    return mop[0] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic eff_sign(input logic sgn);
`ifdef SIGNED_OPS_EN
    return sgn;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation and check result, destination, latency and pulse width.
  // inject=1 pulses start with unrelated operands while the unit is busy.
  task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dest, input logic sgn,
                        input logic [31:0] exp, input bit inject);
    int cycles;
    bit got;
    int exp_lat;
    exp_lat = (mop[1] && b == 32'd0) ? 1 : 33;
    @(negedge clk);
    start    = 1'b1;
    op       = mop;
    src_a    = a;
    src_b    = b;
    dest_reg = dest;
`ifdef SIGNED_OPS_EN
    sign_en  = sgn;
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = ~mop;
    src_a    = $urandom;
    src_b    = $urandom;
    dest_reg = ~dest;
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    cycles = 0;
    got = 0;
    while (!got && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) begin
        got = 1;
      end else if (inject && cycles == 5) begin
        start    = 1'b1;
        op       = $urandom_range(0, 3);
        src_a    = $urandom;
        src_b    = $urandom;
        dest_reg = $urandom_range(0, 31);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, " latency"}, 64'(cycles), 64'(exp_lat));
    check_eq({tag, " data"}, 64'(wb_write_data), 64'(exp));
    check_eq({tag, " reg"}, 64'(wb_write_reg), 64'(dest));
    check_eq({tag, " we"}, 64'(wb_reg_write), 64'd1);
    @(posedge clk);
    #1;
    check_eq({tag, " done_clear"}, 64'(done), 64'd0);
    check_eq({tag, " busy_clear"}, 64'(busy), 64'd0);
    check_eq({tag, " data_hold"}, 64'(wb_write_data), 64'(exp));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rd;
    logic        rs;
    int          pulses;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    start    = 1'b1;
    op       = 2'b00;
    src_a    = 32'd7;
    src_b    = 32'd6;
    dest_reg = 5'd3;
`ifdef SIGNED_OPS_EN
    sign_en  = 1'b0;
`endif

    // Reset held with start asserted: everything stays quiet
    repeat (3) begin
      @(negedge clk);
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst done", 64'(done), 64'd0);
      check_eq("rst we", 64'(wb_reg_write), 64'd0);
      check_eq("rst reg", 64'(wb_write_reg), 64'd0);
      check_eq("rst data", 64'(wb_write_data), 64'd0);
    end
    start = 1'b0;
    rst   = 1'b1;

    // Directed cases
    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd3, 1'b0, 32'd42, 0);
    run_op("mulhi_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'hFFFF_FFFE, 0);
    run_op("mullo_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b0, 32'h0000_0001, 0);
    run_op("div100_7", 2'b10, 32'd100, 32'd7, 5'd4, 1'b0, 32'd14, 0);
    run_op("rem100_7", 2'b11, 32'd100, 32'd7, 5'd5, 1'b0, 32'd2, 0);
    run_op("div5_0", 2'b10, 32'd5, 32'd0, 5'd6, 1'b0, 32'hFFFF_FFFF, 0);
    run_op("rem5_0", 2'b11, 32'd5, 32'd0, 5'd7, 1'b0, 32'd5, 0);
    run_op("inject", 2'b00, 32'd1234, 32'd5678, 5'd12, 1'b0, 32'd7006652, 1);

    // Reset at iteration 10 aborts the operation without write-back
    @(negedge clk);
    start    = 1'b1;
    op       = 2'b00;
    src_a    = 32'd123;
    src_b    = 32'd45;
    dest_reg = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_eq("abort pulses", 64'(pulses), 64'd0);
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort data", 64'(wb_write_data), 64'd0);
    run_op("after_abort", 2'b01, 32'h8000_0000, 32'd6, 5'd21, 1'b0, 32'd3, 0);

`ifdef SIGNED_OPS_EN
    run_op("sdiv-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1, 32'hFFFF_FFFD, 0);
    run_op("srem-7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1, 32'hFFFF_FFFF, 0);
    run_op("smin_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1, 32'h8000_0000, 0);
    run_op("srem_dz", 2'b11, 32'hFFFF_FFF9, 32'd0, 5'd4, 1'b1, 32'hFFFF_FFF9, 0);
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      rd = 5'($urandom_range(0, 31));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), rop, ra, rb, rd, rs,
             model(rop, ra, rb, eff_sign(rs)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
